// File: rtl/ps_slot_scheduler.sv
// Two-requester byte scheduler feeding the 8:1 serializer in fixed-length slots.
// Define SCH_FIXED_PRIO_EN for fixed priority (lane 0 wins ties); default is round robin.
module ps_slot_scheduler #(
   parameter int unsigned DATA_W          = 8,
   parameter int unsigned SLOT_LEN        = 8,
   parameter int unsigned INIT_IDLE_SLOTS = 4
) (
   input  logic              clk_PS,
   input  logic              reset,
   input  logic              req_valid_0,
   input  logic [DATA_W-1:0] req_data_0,
   output logic              req_ready_0,
   input  logic              req_valid_1,
   input  logic [DATA_W-1:0] req_data_1,
   output logic              req_ready_1,
   output logic              valid_out_PS,
   output logic [DATA_W-1:0] data_out_PS,
   output logic              slot_start,
   output logic              link_up
);

   localparam int unsigned CNT_W = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_LEN - 1);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [0:0]        state_q, state_d;
   logic [3:0]        idle_q, idle_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              start_q, start_d;
   logic              boundary, arb_en, grant_0, grant_1;

   assign boundary = (cnt_q == CNT_LAST);
   assign arb_en   = boundary && (state_q == ST_RUN);

`ifdef SCH_FIXED_PRIO_EN
   always_comb begin
      grant_0 = arb_en & req_valid_0;
      grant_1 = arb_en & req_valid_1 & ~req_valid_0;
   end
`else
   // rr_q names the lane favoured on a tie; it moves off a lane once that lane is granted
   logic rr_q, rr_d;

   always_comb begin
      grant_0 = arb_en & req_valid_0 & (~req_valid_1 | ~rr_q);
      grant_1 = arb_en & req_valid_1 & (~req_valid_0 |  rr_q);
      rr_d    = rr_q;
      if (grant_0) rr_d = 1'b1;
      else if (grant_1) rr_d = 1'b0;
   end

   always_ff @(posedge clk_PS or posedge reset) begin
      if (reset) rr_q <= 1'b0;
      else       rr_q <= rr_d;
   end
`endif

   always_comb begin
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = state_q;
      idle_d  = idle_q;
      start_d = boundary;
      valid_d = valid_q;
      data_d  = data_q;
      if (boundary) begin
         if (state_q == ST_INIT) begin
            if ((32'(idle_q) + 32'd1) >= INIT_IDLE_SLOTS) state_d = ST_RUN;
            else                                         idle_d  = idle_q + 4'd1;
         end
         valid_d = grant_0 | grant_1;
         if (grant_0)      data_d = req_data_0;
         else if (grant_1) data_d = req_data_1;
         else              data_d = '0;
      end
   end

   always_ff @(posedge clk_PS or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         state_q <= ST_INIT;
         idle_q  <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         start_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         state_q <= state_d;
         idle_q  <= idle_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         start_q <= start_d;
      end
   end

   assign req_ready_0  = grant_0;
   assign req_ready_1  = grant_1;
   assign valid_out_PS = valid_q;
   assign data_out_PS  = data_q;
   assign slot_start   = start_q;
   assign link_up      = (state_q == ST_RUN);

endmodule

// File: tb/tb_ps_slot_scheduler.sv
// Randomized scoreboard bench for ps_slot_scheduler; honours SCH_FIXED_PRIO_EN when defined.
module tb_ps_slot_scheduler;

   localparam int unsigned DW = 8;
   localparam int unsigned SL = 8;
   localparam int unsigned NI = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid_0, req_valid_1;
   logic [DW-1:0] req_data_0, req_data_1;
   logic          req_ready_0, req_ready_1;
   logic          valid_out_PS, slot_start, link_up;
   logic [DW-1:0] data_out_PS;

   always #5 clk = ~clk;

   ps_slot_scheduler #(.DATA_W(DW), .SLOT_LEN(SL), .INIT_IDLE_SLOTS(NI)) dut (
      .clk_PS(clk), .reset(reset),
      .req_valid_0(req_valid_0), .req_data_0(req_data_0), .req_ready_0(req_ready_0),
      .req_valid_1(req_valid_1), .req_data_1(req_data_1), .req_ready_1(req_ready_1),
      .valid_out_PS(valid_out_PS), .data_out_PS(data_out_PS),
      .slot_start(slot_start), .link_up(link_up)
   );

   typedef struct {
      logic          v;
      logic [DW-1:0] d;
      logic          r0;
      logic          r1;
   } exp_t;

   exp_t          expq[$];
   int unsigned   total = 0, bad = 0;
   int            cyc = 0;
   bit            in_rst = 1'b1;
   bit            hold[2];
   logic [DW-1:0] hbyte[2];
   int            last_win = 1;
   int            pstart[2];
   logic          cur_v = 1'b0, pend_v = 1'b0;
   logic [DW-1:0] cur_d = '0, pend_d = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   // Requesters hold a byte until the model grants it; idle lanes may glitch valid off-boundary.
   task automatic drive();
      bit            bnd;
      logic          v[2];
      logic [DW-1:0] d[2];
      exp_t          e;
      int            w;
      bnd = (cyc % SL) == SL - 1;
      for (int l = 0; l < 2; l++) begin
         v[l] = 1'b0;
         d[l] = '0;
         if (!hold[l] && !bnd && $urandom_range(0, 99) < pstart[l]) begin
            hold[l]  = 1'b1;
            hbyte[l] = DW'($urandom);
         end
         if (hold[l]) begin
            v[l] = 1'b1;
            d[l] = hbyte[l];
         end else if (!bnd && $urandom_range(0, 5) == 0) begin
            v[l] = 1'b1;
            d[l] = DW'($urandom);
         end
      end
      req_valid_0 = v[0]; req_data_0 = d[0];
      req_valid_1 = v[1]; req_data_1 = d[1];
      if (bnd) begin
         e = '{v: 1'b0, d: '0, r0: 1'b0, r1: 1'b0};
         w = -1;
         if (cyc / SL >= NI) begin
            if (hold[0] && hold[1]) begin
`ifdef SCH_FIXED_PRIO_EN
               w = 0;
`else
               w = 1 - last_win;
`endif
            end else if (hold[0]) w = 0;
            else if (hold[1]) w = 1;
         end
         if (w >= 0) begin
            e.v  = 1'b1;
            e.d  = hbyte[w];
            e.r0 = (w == 0);
            e.r1 = (w == 1);
            last_win = w;
            hold[w]  = 1'b0;
         end
         expq.push_back(e);
      end
   endtask

   task automatic release_rst();
      @(posedge clk);
      #2;
      reset  = 1'b0;
      in_rst = 1'b0;
      cyc    = 0;
      drive();
   endtask

   task automatic step();
      @(posedge clk);
      #2;
      cyc++;
      drive();
   endtask

   task automatic mid_reset();
      do step(); while ((cyc % SL) != 3);
      #1;
      reset  = 1'b1;
      in_rst = 1'b1;
      #1;
      chk("rst_valid", valid_out_PS, 0);
      chk("rst_data", data_out_PS, 0);
      chk("rst_slot_start", slot_start, 0);
      chk("rst_link_up", link_up, 0);
      chk("rst_ready", {req_ready_0, req_ready_1}, 0);
      last_win = 1;
      repeat (2) @(posedge clk);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (in_rst) begin
         cur_v = 1'b0; cur_d = '0; pend_v = 1'b0; pend_d = '0;
         expq.delete();
      end else begin
         if ((cyc % SL) == 0 && cyc > 0) begin
            cur_v = pend_v;
            cur_d = pend_d;
         end
         chk("slot_start", slot_start, ((cyc % SL) == 0 && cyc > 0));
         chk("link_up", link_up, (cyc >= int'(NI * SL)));
         chk("valid_out", valid_out_PS, cur_v);
         chk("data_out", data_out_PS, cur_d);
         if ((cyc % SL) == SL - 1) begin
            if (expq.size() == 0) begin
               chk("scoreboard_empty", 1, 0);
            end else begin
               e = expq.pop_front();
               chk("ready_0", req_ready_0, e.r0);
               chk("ready_1", req_ready_1, e.r1);
               pend_v = e.v;
               pend_d = e.d;
            end
         end else begin
            chk("ready_offslot", {req_ready_0, req_ready_1}, 0);
         end
      end
   end

   initial begin
      reset = 1'b1;
      req_valid_0 = 1'b0; req_data_0 = '0;
      req_valid_1 = 1'b0; req_data_1 = '0;
      hold[0] = 1'b0; hold[1] = 1'b0;
      hbyte[0] = '0; hbyte[1] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("init_valid", valid_out_PS, 0);
      chk("init_data", data_out_PS, 0);
      chk("init_slot_start", slot_start, 0);
      chk("init_link_up", link_up, 0);
      chk("init_ready", {req_ready_0, req_ready_1}, 0);
      for (int seg = 0; seg < 6; seg++) begin
         case (seg % 4)
            0: begin pstart[0] = 0;   pstart[1] = 0;   end
            1: begin pstart[0] = 100; pstart[1] = 100; end
            2: begin pstart[0] = 100; pstart[1] = 0;   end
            default: begin pstart[0] = 30; pstart[1] = 40; end
         endcase
         release_rst();
         repeat (int'(SL * (NI + 14))) step();
         if (seg < 5) mid_reset();
      end
      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
